branch_resolution_unit: RTL and testbench

Execute-side counterpart of the fetch-stage branch target buffer. Records each fetched PC with its BTB prediction in an in-order queue and checks it against the real outcome when the instruction resolves. Generates the BTB training strobes (`prev_pc`, `branch_pc`, `jump_pc`, `was_taken`, `jumped`) and a flush/redirect to fetch on a misprediction. Sits between the execute stage and fetch.

---
 rtl/bru_pkg.sv | 17 +
 rtl/bru_pred_fifo.sv | 60 ++++++
 rtl/branch_resolution_unit.sv | 142 ++++++++++++++
 tb/tb_branch_resolution_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared types for the branch resolution unit.
// Optional BRU_STATS_EN adds resolve/mispredict counters at the top level.
package bru_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] pred;
  } bru_entry_t;

  typedef enum logic {
    RUN,
    FLUSH
  } bru_state_t;

  localparam int INSN_BYTES = 4;

endpackage

// File: rtl/bru_pred_fifo.sv
// In-order queue of fetched PCs and their BTB predictions.
// A push while full is accepted only together with a pop; clear wins over both.
module bru_pred_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       push,
  input  bru_entry_t din,
  input  logic       pop,
  input  logic       clear,
  output bru_entry_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic [AW:0]   cnt;
  bru_entry_t    mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else if (clear) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop)  rd <= rd + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr] <= din;
  end

  assign dout  = mem[rd];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/branch_resolution_unit.sv
// Resolves queued BTB predictions against execute outcomes; trains BTB, flushes.
// Optional BRU_STATS_EN adds resolved_count / mispredict_count outputs.
module branch_resolution_unit
  import bru_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        en,
  input  logic        fetch_valid,
  input  logic [63:0] fetch_pc,
  input  logic [63:0] predicted_pc,
  input  logic        resolve_valid,
  input  logic        resolve_is_branch,
  input  logic        resolve_taken,
  input  logic        resolve_is_jump,
  input  logic [63:0] resolve_target,
  output logic [63:0] prev_pc,
  output logic [63:0] branch_pc,
  output logic [63:0] jump_pc,
  output logic        was_taken,
  output logic        jumped,
  output logic        flush,
  output logic [63:0] redirect_pc,
  output logic        full,
  output logic        empty
`ifdef BRU_STATS_EN
  ,
  output logic [31:0] resolved_count,
  output logic [31:0] mispredict_count
`endif
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  bru_state_t  state;
  logic [FW-1:0] fcnt;

  bru_entry_t  head;
  bru_entry_t  din;
  logic        run;
  logic        redirect;
  logic        pop_ok;
  logic        mis;
  logic        push_ok;
  logic [63:0] seq_pc;
  logic [63:0] actual;
  logic [63:0] expected;

  assign run      = (state == RUN);
  assign redirect = resolve_is_jump | (resolve_is_branch & resolve_taken);
  assign seq_pc   = head.pc + 64'(INSN_BYTES);
  assign actual   = redirect ? resolve_target : seq_pc;
  assign expected = (head.pred != '0) ? head.pred : seq_pc;

  assign pop_ok  = en & run & resolve_valid & ~empty;
  assign mis     = pop_ok & (actual != expected);
  // The push is younger than a mispredicting pop, so it is squashed too.
  assign push_ok = en & run & fetch_valid & ~mis;

  assign din.pc   = fetch_pc;
  assign din.pred = predicted_pc;

  bru_pred_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .arst_n(arst_n),
    .push  (push_ok),
    .din   (din),
    .pop   (pop_ok),
    .clear (mis),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= RUN;
      fcnt        <= '0;
      prev_pc     <= '0;
      branch_pc   <= '0;
      jump_pc     <= '0;
      was_taken   <= 1'b0;
      jumped      <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      was_taken <= 1'b0;
      jumped    <= 1'b0;
      if (en) begin
        unique case (state)
          RUN: begin
            if (pop_ok) begin
              if (resolve_is_jump) begin
                jumped  <= 1'b1;
                prev_pc <= head.pc;
                jump_pc <= resolve_target;
              end else if (resolve_is_branch && resolve_taken) begin
                was_taken <= 1'b1;
                prev_pc   <= head.pc;
                branch_pc <= resolve_target;
              end
            end
            if (mis) begin
              redirect_pc <= actual;
              flush       <= 1'b1;
              fcnt        <= FW'(FLUSH_CYCLES);
              state       <= FLUSH;
            end
          end
          FLUSH: begin
            fcnt <= fcnt - 1'b1;
            if (fcnt == FW'(1)) begin
              flush <= 1'b0;
              state <= RUN;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      resolved_count   <= '0;
      mispredict_count <= '0;
    end else begin
      if (pop_ok && resolved_count != '1)
        resolved_count <= resolved_count + 1'b1;
      if (mis && mispredict_count != '1)
        mispredict_count <= mispredict_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit with a queue-based reference model.
module tb_branch_resolution_unit;

  localparam int DEPTH = 4;
  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        en;
  logic        fetch_valid;
  logic [63:0] fetch_pc;
  logic [63:0] predicted_pc;
  logic        resolve_valid;
  logic        resolve_is_branch;
  logic        resolve_taken;
  logic        resolve_is_jump;
  logic [63:0] resolve_target;
  logic [63:0] prev_pc;
  logic [63:0] branch_pc;
  logic [63:0] jump_pc;
  logic        was_taken;
  logic        jumped;
  logic        flush;
  logic [63:0] redirect_pc;
  logic        full;
  logic        empty;
`ifdef BRU_STATS_EN
  logic [31:0] resolved_count;
  logic [31:0] mispredict_count;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  branch_resolution_unit #(
    .DEPTH(DEPTH),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .en               (en),
    .fetch_valid      (fetch_valid),
    .fetch_pc         (fetch_pc),
    .predicted_pc     (predicted_pc),
    .resolve_valid    (resolve_valid),
    .resolve_is_branch(resolve_is_branch),
    .resolve_taken    (resolve_taken),
    .resolve_is_jump  (resolve_is_jump),
    .resolve_target   (resolve_target),
    .prev_pc          (prev_pc),
    .branch_pc        (branch_pc),
    .jump_pc          (jump_pc),
    .was_taken        (was_taken),
    .jumped           (jumped),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .full             (full),
    .empty            (empty)
`ifdef BRU_STATS_EN
    ,
    .resolved_count   (resolved_count),
    .mispredict_count (mispredict_count)
`endif
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  // Reference model: a plain queue plus a count of remaining flush cycles.
  typedef struct {
    logic [63:0] pc;
    logic [63:0] pred;
  } ent_t;

  ent_t        q[$];
  int          m_left = 0;
  logic        m_flush = 0;
  logic        m_wt = 0;
  logic        m_jm = 0;
  logic [63:0] m_prev = 0;
  logic [63:0] m_br = 0;
  logic [63:0] m_jp = 0;
  logic [63:0] m_redir = 0;
  int unsigned m_res = 0;
  int unsigned m_mis = 0;

  function automatic void model_reset();
    q.delete();
    m_left = 0;
    m_flush = 0;
    m_wt = 0;
    m_jm = 0;
    m_prev = 0;
    m_br = 0;
    m_jp = 0;
    m_redir = 0;
    m_res = 0;
    m_mis = 0;
  endfunction

  always @(negedge arst_n) model_reset();

  always @(posedge clk) begin
    if (!arst_n) begin
      model_reset();
    end else begin
      m_wt = 0;
      m_jm = 0;
      if (en) begin
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_flush = 0;
        end else begin
          bit mis;
          mis = 0;
          if (resolve_valid && q.size() > 0) begin
            ent_t e;
            logic [63:0] act;
            logic [63:0] exp_pc;
            e = q.pop_front();
            m_res++;
            act = (resolve_is_jump || (resolve_is_branch && resolve_taken))
                  ? resolve_target : e.pc + 64'd4;
            exp_pc = (e.pred != 0) ? e.pred : e.pc + 64'd4;
            if (resolve_is_jump) begin
              m_jm = 1;
              m_prev = e.pc;
              m_jp = resolve_target;
            end else if (resolve_is_branch && resolve_taken) begin
              m_wt = 1;
              m_prev = e.pc;
              m_br = resolve_target;
            end
            if (act != exp_pc) begin
              mis = 1;
              m_mis++;
              q.delete();
              m_redir = act;
              m_flush = 1;
              m_left = FLUSH_CYCLES;
            end
          end
          if (fetch_valid && !mis && q.size() < DEPTH) begin
            ent_t n;
            n.pc = fetch_pc;
            n.pred = predicted_pc;
            q.push_back(n);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("prev_pc", prev_pc, m_prev);
    chk("branch_pc", branch_pc, m_br);
    chk("jump_pc", jump_pc, m_jp);
    chk("was_taken", 64'(was_taken), 64'(m_wt));
    chk("jumped", 64'(jumped), 64'(m_jm));
    chk("flush", 64'(flush), 64'(m_flush));
    chk("redirect_pc", redirect_pc, m_redir);
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("empty", 64'(empty), 64'(q.size() == 0));
`ifdef BRU_STATS_EN
    chk("resolved_count", 64'(resolved_count), 64'(m_res));
    chk("mispredict_count", 64'(mispredict_count), 64'(m_mis));
`endif
  end

  task automatic idle();
    fetch_valid = 0;
    fetch_pc = 0;
    predicted_pc = 0;
    resolve_valid = 0;
    resolve_is_branch = 0;
    resolve_taken = 0;
    resolve_is_jump = 0;
    resolve_target = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] pc, input logic [63:0] pred);
    fetch_valid = 1;
    fetch_pc = pc;
    predicted_pc = pred;
  endtask

  task automatic resolve(input logic br, input logic tk, input logic jp,
                         input logic [63:0] tgt);
    resolve_valid = 1;
    resolve_is_branch = br;
    resolve_taken = tk;
    resolve_is_jump = jp;
    resolve_target = tgt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    arst_n = 0;
    en = 1;
    idle();
    step();
    step();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    arst_n = 1;
    step();

    // Non-control instruction, correctly predicted fall-through.
    push(64'h100, 64'h0);
    step();
    idle();
    resolve(0, 0, 0, 64'h0);
    step();
    idle();
    chk("t1_wt", 64'(was_taken), 64'd0);
    chk("t1_jm", 64'(jumped), 64'd0);
    chk("t1_flush", 64'(flush), 64'd0);
    chk("t1_empty", 64'(empty), 64'd1);

    // Correctly predicted taken branch.
    push(64'h200, 64'h400);
    step();
    idle();
    resolve(1, 1, 0, 64'h400);
    step();
    idle();
    chk("t2_wt", 64'(was_taken), 64'd1);
    chk("t2_prev", prev_pc, 64'h200);
    chk("t2_br", branch_pc, 64'h400);
    chk("t2_flush", 64'(flush), 64'd0);
    step();
    chk("t2_wt_pulse", 64'(was_taken), 64'd0);

    // Unpredicted jump with a same-cycle push that must be squashed.
    push(64'h300, 64'h0);
    step();
    idle();
    resolve(0, 0, 1, 64'h800);
    push(64'h304, 64'h0);
    step();
    idle();
    chk("t3_jm", 64'(jumped), 64'd1);
    chk("t3_jp", jump_pc, 64'h800);
    chk("t3_flush0", 64'(flush), 64'd1);
    chk("t3_redir", redirect_pc, 64'h800);
    chk("t3_empty", 64'(empty), 64'd1);
    step();
    chk("t3_flush1", 64'(flush), 64'd1);
    chk("t3_redir1", redirect_pc, 64'h800);
    step();
    chk("t3_flush2", 64'(flush), 64'd0);
    chk("t3_empty2", 64'(empty), 64'd1);

    // Predicted taken but actually not taken.
    push(64'h500, 64'h600);
    step();
    idle();
    resolve(1, 0, 0, 64'h600);
    step();
    idle();
    chk("t4_flush", 64'(flush), 64'd1);
    chk("t4_redir", redirect_pc, 64'h504);
    chk("t4_wt", 64'(was_taken), 64'd0);
    step();
    step();
    chk("t4_flush_end", 64'(flush), 64'd0);

    // Fill, push+pop while full, dropped push, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      push(64'h1000 + 64'(4 * i), 64'h0);
      step();
    end
    idle();
    chk("t5_full", 64'(full), 64'd1);
    push(64'h1010, 64'h0);
    resolve(0, 0, 1, 64'h1004);
    step();
    idle();
    chk("t5_full_pp", 64'(full), 64'd1);
    chk("t5_prev0", prev_pc, 64'h1000);
    chk("t5_flush", 64'(flush), 64'd0);
    push(64'h1014, 64'h0);
    step();
    idle();
    chk("t5_drop_full", 64'(full), 64'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      logic [63:0] pc;
      pc = 64'h1000 + 64'(4 * i);
      resolve(0, 0, 1, pc + 64'd4);
      step();
      idle();
      chk("t5_order", prev_pc, pc);
    end
    chk("t5_empty", 64'(empty), 64'd1);
    resolve(0, 0, 1, 64'h2000);
    step();
    idle();
    chk("t5_pop_empty", 64'(jumped), 64'd0);

    // Pipeline hold: nothing moves while en is low.
    push(64'h600, 64'h0);
    step();
    idle();
    en = 0;
    resolve(0, 0, 1, 64'h604);
    step();
    chk("t6_hold_jm", 64'(jumped), 64'd0);
    chk("t6_hold_empty", 64'(empty), 64'd0);
    en = 1;
    step();
    idle();
    chk("t6_jm", 64'(jumped), 64'd1);
    chk("t6_prev", prev_pc, 64'h600);

    // Reset in the middle of a flush window.
    push(64'h700, 64'h0);
    step();
    idle();
    resolve(0, 0, 1, 64'h900);
    step();
    idle();
    chk("t7_flush", 64'(flush), 64'd1);
    #2;
    arst_n = 0;
    #1;
    chk("t7_rst_flush", 64'(flush), 64'd0);
    chk("t7_rst_empty", 64'(empty), 64'd1);
`ifdef BRU_STATS_EN
    chk("t7_rst_res", 64'(resolved_count), 64'd0);
    chk("t7_rst_mis", 64'(mispredict_count), 64'd0);
`endif
    step();
    arst_n = 1;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
